// File: rtl/frog_move_gen.sv
// frog_move_gen: turns four raw direction keys into one-cycle L/R/U/D move
// pulses for the frog light cell grid. Each key is synchronized and
// edge-detected. One move is chosen per cycle (U > D > L > R). Moves that
// would leave the grid are suppressed, and issued moves are rate-limited by a
// cooldown counter. The frog position is tracked as row/col.
// Optional build macro FROG_AUTO_REPEAT_EN: a held key re-issues its
// direction every REPEAT_CYCLES cycles.
module frog_move_gen #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int START_ROW = 7,
  parameter int START_COL = 3,
  parameter int COOLDOWN  = 4
`ifdef FROG_AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      keyL,
  input  logic                      keyR,
  input  logic                      keyU,
  input  logic                      keyD,
  input  logic                      hit,
  output logic                      L,
  output logic                      R,
  output logic                      U,
  output logic                      D,
  output logic                      win,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic [$clog2(COLS)-1:0]   col
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int CDW = $clog2(COOLDOWN + 1);

  localparam logic [RW-1:0]  ROW_START = RW'(START_ROW);
  localparam logic [CW-1:0]  COL_START = CW'(START_COL);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]  COL_LAST  = CW'(COLS - 1);
  localparam logic [CDW-1:0] CD_LOAD   = CDW'(COOLDOWN);

  // Key lanes, packed as {U, D, L, R}. The bit order is the arbitration order.
  localparam int KU = 3;
  localparam int KD = 2;
  localparam int KL = 1;
  localparam int KR = 0;

  logic [3:0]     keys;
  logic [3:0]     s1, s2, prev;
  logic [3:0]     rep_req;
  logic [3:0]     req;
  logic [3:0]     grant;
  logic           issue;
  logic [CDW-1:0] cd;

  assign keys = {keyU, keyD, keyL, keyR};

  // Two-flop synchronizer plus edge history. All three stages reset to 1, so a
  // key held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
    end else begin
      s1   <= keys;
      s2   <= s1;
      prev <= s2;
    end
  end

`ifdef FROG_AUTO_REPEAT_EN
  localparam int                RPW     = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPW-1:0]    REP_TOP = RPW'(REPEAT_CYCLES - 1);

  logic [RPW-1:0] rep_cnt;
  logic [3:0]     rep_dir;
  logic           rep_act;
  logic           rep_held;

  assign rep_held = |(rep_dir & s2);
  assign rep_req  = (rep_act && rep_cnt == REP_TOP) ? rep_dir : 4'b0000;

  // Repeat timer for the last issued direction. It restarts on every issue,
  // saturates at the request point, and disarms on release or hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt <= '0;
      rep_dir <= '0;
      rep_act <= 1'b0;
    end else if (hit) begin
      rep_cnt <= '0;
      rep_act <= 1'b0;
    end else if (issue) begin
      rep_cnt <= '0;
      rep_dir <= grant;
      rep_act <= 1'b1;
    end else if (!rep_held) begin
      rep_cnt <= '0;
      rep_act <= 1'b0;
    end else if (rep_act && rep_cnt != REP_TOP) begin
      rep_cnt <= rep_cnt + RPW'(1);
    end
  end
`else
  assign rep_req = 4'b0000;
`endif

  // Fixed-priority pick and boundary check. An out-of-grid winner yields an
  // empty grant, so it neither moves nor starts a cooldown.
  always_comb begin
    req   = (s2 & ~prev) | rep_req;
    grant = '0;
    if (req[KU])      grant[KU] = (row != '0);
    else if (req[KD]) grant[KD] = (row != ROW_LAST);
    else if (req[KL]) grant[KL] = (col != '0);
    else if (req[KR]) grant[KR] = (col != COL_LAST);
    if (cd != '0 || hit) grant = '0;
  end

  assign issue = |grant;

  // Pulse, position and cooldown registers. Priority is reset, then hit, then
  // move.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {U, D, L, R} <= 4'b0000;
      win          <= 1'b0;
      row          <= ROW_START;
      col          <= COL_START;
      cd           <= '0;
    end else if (hit) begin
      {U, D, L, R} <= 4'b0000;
      win          <= 1'b0;
      row          <= ROW_START;
      col          <= COL_START;
      cd           <= CD_LOAD;
    end else begin
      {U, D, L, R} <= grant;
      win          <= grant[KU] && (row == RW'(1));
      if (grant[KU]) row <= row - RW'(1);
      if (grant[KD]) row <= row + RW'(1);
      if (grant[KL]) col <= col - CW'(1);
      if (grant[KR]) col <= col + CW'(1);
      if (issue)          cd <= CD_LOAD;
      else if (cd != '0)  cd <= cd - CDW'(1);
    end
  end

endmodule

// File: tb/tb_frog_move_gen.sv
// Bench for frog_move_gen in its default build, without auto-repeat.
// First, a table of directed vectors walks through reset, latency, priority,
// cooldown, boundaries, win and hit. Then random keys, hits and resets are
// compared against an edge-indexed reference model.
module tb_frog_move_gen;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int SR   = 7;
  localparam int SC   = 3;
  localparam int CD   = 4;
  localparam int TBL_N = 86;
  localparam int RND_N = 2500;

  localparam logic [3:0] KU = 4'b1000;
  localparam logic [3:0] KD = 4'b0100;
  localparam logic [3:0] KL = 4'b0010;
  localparam logic [3:0] KR = 4'b0001;
  localparam logic [3:0] K0 = 4'b0000;

  logic clk = 1'b0;
  logic reset, keyL, keyR, keyU, keyD, hit;
  logic L, R, U, D, win;
  logic [2:0] row, col;

  always #5 clk = ~clk;

  frog_move_gen dut (
    .clk(clk), .reset(reset),
    .keyL(keyL), .keyR(keyR), .keyU(keyU), .keyD(keyD),
    .hit(hit),
    .L(L), .R(R), .U(U), .D(D), .win(win),
    .row(row), .col(col)
  );

  int total = 0;
  int bad   = 0;

  // Reference model, indexed by clock edge number n. A key counts as a press
  // at edge n when it was sampled 0 at edge n-3 and 1 at edge n-2, and both
  // samples were taken after the last reset edge. Cooldown is tracked as the
  // edge of the last load, not as a counter.
  logic [3:0] kh [0:4095];
  int n        = 0;
  int last_rst = -1;
  int last_ld  = -1000;
  int m_row    = SR;
  int m_col    = SC;
  logic [3:0] m_p;
  logic       m_w;

  task automatic model_edge(input logic rn, input logic h, input logic [3:0] k);
    logic [3:0] rq;
    kh[n] = k;
    m_p   = 4'b0000;
    m_w   = 1'b0;
    if (!rn) begin
      m_row = SR; m_col = SC; last_rst = n; last_ld = -1000;
    end else if (h) begin
      m_row = SR; m_col = SC; last_ld = n;
    end else begin
      rq = (n - 3 > last_rst) ? (kh[n-2] & ~kh[n-3]) : 4'b0000;
      if (n - last_ld > CD) begin
        if (rq[3]) begin
          if (m_row > 0) begin m_p = KU; m_w = (m_row == 1); m_row--; last_ld = n; end
        end else if (rq[2]) begin
          if (m_row < ROWS - 1) begin m_p = KD; m_row++; last_ld = n; end
        end else if (rq[1]) begin
          if (m_col > 0) begin m_p = KL; m_col--; last_ld = n; end
        end else if (rq[0]) begin
          if (m_col < COLS - 1) begin m_p = KR; m_col++; last_ld = n; end
        end
      end
    end
  endtask

  // Apply one cycle of inputs. The bench is at a negedge on entry and returns
  // at the negedge after the next active edge, which is where outputs are read.
  task automatic step(input logic rn, input logic h, input logic [3:0] k);
    reset = rn; hit = h;
    keyU = k[3]; keyD = k[2]; keyL = k[1]; keyR = k[0];
    model_edge(rn, h, k);
    n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int e, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, e, got, want);
    end
  endtask

  // Directed vectors. A stimulus entry holds its inputs for cnt edges starting
  // at edge e; every other edge is idle. An expectation entry gives the pulses
  // and win flag at edge e, and the row/col that hold from that edge on.
  typedef struct { int e; int cnt; logic rn; logic h; logic [3:0] k; } stim_t;
  typedef struct { int e; logic [3:0] p; logic w; int r; int c; } exp_t;

  stim_t st[$];
  exp_t  ex[$];

  task automatic add_stim(input int e, input int cnt, input logic rn, input logic h, input logic [3:0] k);
    stim_t s;
    s.e = e; s.cnt = cnt; s.rn = rn; s.h = h; s.k = k;
    st.push_back(s);
  endtask

  task automatic add_exp(input int e, input logic [3:0] p, input logic w, input int r, input int c);
    exp_t x;
    x.e = e; x.p = p; x.w = w; x.r = r; x.c = c;
    ex.push_back(x);
  endtask

  logic [3:0] tk [0:TBL_N-1];
  logic       trn[0:TBL_N-1];
  logic       th [0:TBL_N-1];

  initial begin
    int xi, er, ec;
    logic [3:0] rk;
    logic rrn, rh;

    // reset with keyU held, then keep holding it: no pulse
    add_stim(0, 3, 1'b0, 1'b0, KU);
    add_stim(3, 4, 1'b1, 1'b0, KU);
    // D at the bottom row is invalid
    add_stim(8, 1, 1'b1, 1'b0, KD);
    // basic L with a 2-edge latency
    add_stim(10, 2, 1'b1, 1'b0, KL);
    // U and R together: U wins; R re-press inside cooldown lost, later taken
    add_stim(16, 2, 1'b1, 1'b0, KU | KR);
    add_stim(19, 1, 1'b1, 1'b0, KR);
    add_stim(22, 2, 1'b1, 1'b0, KR);
    // walk to col 0, L at the edge is invalid, immediate R still issues
    add_stim(27, 1, 1'b1, 1'b0, KL);
    add_stim(32, 1, 1'b1, 1'b0, KL);
    add_stim(37, 1, 1'b1, 1'b0, KL);
    add_stim(44, 1, 1'b1, 1'b0, KL);
    add_stim(45, 1, 1'b1, 1'b0, KR);
    // climb to row 0 for the win
    add_stim(50, 1, 1'b1, 1'b0, KU);
    add_stim(55, 1, 1'b1, 1'b0, KU);
    add_stim(60, 1, 1'b1, 1'b0, KU);
    add_stim(65, 1, 1'b1, 1'b0, KU);
    add_stim(70, 1, 1'b1, 1'b0, KU);
    add_stim(75, 1, 1'b1, 1'b0, KU);
    // D edge coinciding with hit is dropped; hit starts a cooldown
    add_stim(76, 1, 1'b1, 1'b0, KD);
    add_stim(78, 1, 1'b1, 1'b1, K0);
    add_stim(79, 1, 1'b1, 1'b0, KU);
    add_stim(81, 1, 1'b1, 1'b0, KU);

    add_exp(0,  K0, 1'b0, 7, 3);
    add_exp(12, KL, 1'b0, 7, 2);
    add_exp(18, KU, 1'b0, 6, 2);
    add_exp(24, KR, 1'b0, 6, 3);
    add_exp(29, KL, 1'b0, 6, 2);
    add_exp(34, KL, 1'b0, 6, 1);
    add_exp(39, KL, 1'b0, 6, 0);
    add_exp(47, KR, 1'b0, 6, 1);
    add_exp(52, KU, 1'b0, 5, 1);
    add_exp(57, KU, 1'b0, 4, 1);
    add_exp(62, KU, 1'b0, 3, 1);
    add_exp(67, KU, 1'b0, 2, 1);
    add_exp(72, KU, 1'b0, 1, 1);
    add_exp(77, KU, 1'b1, 0, 1);
    add_exp(78, K0, 1'b0, 7, 3);
    add_exp(83, KU, 1'b0, 6, 3);

    for (int e = 0; e < TBL_N; e++) begin
      tk[e] = K0; trn[e] = 1'b1; th[e] = 1'b0;
    end
    foreach (st[i]) begin
      for (int e = st[i].e; e < st[i].e + st[i].cnt; e++) begin
        tk[e] = st[i].k; trn[e] = st[i].rn; th[e] = st[i].h;
      end
    end

    reset = 1'b0; hit = 1'b0; keyU = 1'b0; keyD = 1'b0; keyL = 1'b0; keyR = 1'b0;

    xi = 0; er = SR; ec = SC;
    for (int e = 0; e < TBL_N; e++) begin
      logic [3:0] ep;
      logic       ew;
      ep = K0; ew = 1'b0;
      if (xi < ex.size() && ex[xi].e == e) begin
        ep = ex[xi].p; ew = ex[xi].w; er = ex[xi].r; ec = ex[xi].c; xi++;
      end
      step(trn[e], th[e], tk[e]);
      chk("tbl_pulse", e, 32'({U, D, L, R}), 32'(ep));
      chk("tbl_win",   e, 32'(win), 32'(ew));
      chk("tbl_row",   e, 32'(row), er);
      chk("tbl_col",   e, 32'(col), ec);
    end

    // random phase against the model
    rk = K0;
    for (int i = 0; i < RND_N; i++) begin
      rrn = ($urandom_range(0, 99) != 0);
      rh  = ($urandom_range(0, 39) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) rk[b] = ~rk[b];
      step(rrn, rh, rk);
      chk("rnd_pulse", n - 1, 32'({U, D, L, R}), 32'(m_p));
      chk("rnd_win",   n - 1, 32'(win), 32'(m_w));
      chk("rnd_row",   n - 1, 32'(row), m_row);
      chk("rnd_col",   n - 1, 32'(col), m_col);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
